// File: rtl/chan_ser_pkg.sv
// Shared defaults and FSM encoding for the channel serializer.
package chan_ser_pkg;
  localparam int DATA_W_DEF    = 32;
  localparam int LANE_W_DEF    = 8;
  localparam int NUM_CHAN_DEF  = 4;
  localparam int DEPTH_DEF     = 4;
  localparam bit MSB_FIRST_DEF = 1'b1;

  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/chan_ser_fifo.sv
// Circular word queue; all DEPTH slots usable, count-based full/empty.
module chan_ser_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/chan_serializer.sv
// Queues {chan,word} requests and serializes each word into LANE_W beats
// driven onto the lane of its destination channel.
module chan_serializer
  import chan_ser_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NUM_CHAN  = NUM_CHAN_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF,
  localparam int CH_W  = $clog2(NUM_CHAN),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req,
  input  logic [CH_W-1:0]            in_chan,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       q_full,
  output logic [CNT_W-1:0]           q_count,
  output logic                       drop_err,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [CH_W-1:0]            out_chan,
  output logic [NUM_CHAN*LANE_W-1:0] out_data,
  output logic                       out_last
);
  localparam int BEATS = DATA_W / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((DATA_W % LANE_W) != 0 || NUM_CHAN < 2 || DEPTH < 2) begin : g_bad_cfg
      $error("chan_serializer: illegal DATA_W/LANE_W/NUM_CHAN/DEPTH combination");
    end
  endgenerate

  logic              push, pop, empty, last_beat;
  logic [CH_W-1:0]   head_chan;
  logic [DATA_W-1:0] head_data;
  logic [LANE_W-1:0] lane;
  logic [BW-1:0]     beat, beat_nxt;
  state_t            state, state_nxt;

  assign push = rst_n && in_req && !q_full;

  chan_ser_fifo #(.W(CH_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({in_chan, in_data}),
    .rdata ({head_chan, head_data}),
    .count (q_count),
    .full  (q_full),
    .empty (empty)
  );

  assign out_valid = (state == SHIFT);
  assign last_beat = (beat == BW'(BEATS - 1));

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_nxt = SHIFT;
        beat_nxt  = '0;
      end
      SHIFT: if (out_ready) begin
        if (last_beat) begin
          // A same-edge push keeps the pipe full with no bubble.
          pop       = 1'b1;
          beat_nxt  = '0;
          state_nxt = (q_count > CNT_W'(1) || push) ? SHIFT : IDLE;
        end else begin
          beat_nxt = beat + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      drop_err <= in_req && q_full;
    end
  end

  always_comb begin
    int sel;
    sel  = MSB_FIRST ? (BEATS - 1 - int'(beat)) : int'(beat);
    lane = LANE_W'(head_data >> (sel * LANE_W));
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (out_valid && head_chan == CH_W'(c)) out_data[c*LANE_W +: LANE_W] = lane;
    end
  end

  assign out_chan = out_valid ? head_chan : '0;
  assign out_last = out_valid && last_beat;
endmodule

// File: tb/tb_chan_serializer.sv
// Scoreboard bench: three serializer configurations, expected beats queued at stimulus time.
module tb_chan_serializer;
  typedef struct {
    logic [1:0]  chan;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_req, out_ready;
  logic [1:0]  in_chan;
  logic [31:0] in_data;
  logic        w_req, w_ready;
  logic [1:0]  w_chan;
  logic [47:0] w_data;

  logic        q_full0, drop0, ov0, ol0, q_full1, drop1, ov1, ol1;
  logic [2:0]  q_count0, q_count1;
  logic [1:0]  oc0, oc1;
  logic [31:0] od0, od1;
  logic        wq_full, wdrop, wov, wol;
  logic [1:0]  wq_count, woc;
  logic [47:0] wod;

  chan_serializer u_msb (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_chan(in_chan), .in_data(in_data),
    .q_full(q_full0), .q_count(q_count0), .drop_err(drop0), .out_ready(out_ready),
    .out_valid(ov0), .out_chan(oc0), .out_data(od0), .out_last(ol0));

  chan_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_chan(in_chan), .in_data(in_data),
    .q_full(q_full1), .q_count(q_count1), .drop_err(drop1), .out_ready(out_ready),
    .out_valid(ov1), .out_chan(oc1), .out_data(od1), .out_last(ol1));

  chan_serializer #(.DATA_W(48), .LANE_W(16), .NUM_CHAN(3), .DEPTH(3)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_req(w_req), .in_chan(w_chan), .in_data(w_data),
    .q_full(wq_full), .q_count(wq_count), .drop_err(wdrop), .out_ready(w_ready),
    .out_valid(wov), .out_chan(woc), .out_data(wod), .out_last(wol));

  int checks = 0;
  int errors = 0;
  beat_t q0[$], q1[$], q2[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int k, input beat_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_beat(input int k, input logic [1:0] ch, input logic [63:0] d, input logic l);
    beat_t e;
    e.chan = ch; e.data = d; e.last = l;
    sb_push(k, e);
  endtask

  // Reference slicing: beat b carries lane idx of the word, placed on lane ch.
  task automatic sb_word(input int k, input logic [1:0] ch, input logic [63:0] d);
    int lw, nb, idx;
    logic [63:0] mask, ln;
    lw   = (k == 2) ? 16 : 8;
    nb   = (k == 2) ? 3 : 4;
    mask = (64'd1 << lw) - 64'd1;
    for (int b = 0; b < nb; b++) begin
      idx = (k == 1) ? b : (nb - 1 - b);
      ln  = (d >> (idx * lw)) & mask;
      sb_beat(k, ch, ln << (int'(ch) * lw), b == nb - 1);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic [1:0] ch,
                     input logic [63:0] d, input logic l);
    beat_t e;
    int sz;
    if (!v) begin
      chk($sformatf("idle_outputs_zero%0d", k), {63'b0, (d != 0 || ch != 0 || l != 0)}, 64'd0);
    end else if (r) begin
      sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
        chk($sformatf("unexpected_beat%0d", k), d, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        case (k)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("beat_data%0d", k), d, e.data);
        chk($sformatf("beat_chan%0d", k), {62'b0, ch}, {62'b0, e.chan});
        chk($sformatf("beat_last%0d", k), {63'b0, l}, {63'b0, e.last});
      end
    end
  endtask

  always @(negedge clk) if (rst_n === 1'b1) mon(0, ov0, out_ready, oc0, {32'b0, od0}, ol0);
  always @(negedge clk) if (rst_n === 1'b1) mon(1, ov1, out_ready, oc1, {32'b0, od1}, ol1);
  always @(negedge clk) if (rst_n === 1'b1) mon(2, wov, w_ready, woc, {16'b0, wod}, wol);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_in(input logic [1:0] ch, input logic [31:0] d);
    sb_word(0, ch, {32'b0, d});
    sb_word(1, ch, {32'b0, d});
  endtask

  initial begin
    int n0, n1, budget;
    rst_n = 1'b0; in_req = 1'b0; in_chan = '0; in_data = '0; out_ready = 1'b1;
    w_req = 1'b0; w_chan = '0; w_data = '0; w_ready = 1'b1;
    tick(3);
    chk("rst_q_count", {61'b0, q_count0}, 64'd0);
    chk("rst_q_full", {63'b0, q_full0}, 64'd0);
    chk("rst_drop_err", {63'b0, drop0}, 64'd0);
    chk("rst_out_valid", {63'b0, ov0}, 64'd0);
    chk("rst_wide_count", {62'b0, wq_count}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic word on channel 2, both beat orders
    sb_beat(0, 2'd2, 64'h00A10000, 1'b0); sb_beat(0, 2'd2, 64'h00B20000, 1'b0);
    sb_beat(0, 2'd2, 64'h00C30000, 1'b0); sb_beat(0, 2'd2, 64'h00D40000, 1'b1);
    sb_beat(1, 2'd2, 64'h00D40000, 1'b0); sb_beat(1, 2'd2, 64'h00C30000, 1'b0);
    sb_beat(1, 2'd2, 64'h00B20000, 1'b0); sb_beat(1, 2'd2, 64'h00A10000, 1'b1);
    in_req = 1'b1; in_chan = 2'd2; in_data = 32'hA1B2C3D4;
    tick(1);
    in_req = 1'b0;
    chk("first_valid_latency", {63'b0, ov0}, 64'd0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov0) n0++;
      if (ov1) n1++;
    end
    chk("valid_cycles_msb", 64'(n0), 64'd4);
    chk("valid_cycles_lsb", 64'(n1), 64'd4);
    tick(1);

    // Back-pressure on beat 1 must hold the beat
    out_ready = 1'b0;
    sb_in(2'd0, 32'h11223344);
    in_req = 1'b1; in_chan = 2'd0; in_data = 32'h11223344;
    tick(1);
    in_req = 1'b0;
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_msb", {32'b0, od0}, 64'h22);
      chk("stall_hold_lsb", {32'b0, od1}, 64'h33);
      chk("stall_last", {63'b0, ol0}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    tick(5);

    // Overfill with downstream stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_req = 1'b1; in_chan = 2'(i); in_data = 32'h01020304 + 32'(i) * 32'h10101010;
      if (i < 4) sb_in(2'(i), 32'h01020304 + 32'(i) * 32'h10101010);
      tick(1);
      if (i == 3) begin
        chk("full_after_4", {63'b0, q_full0}, 64'd1);
        chk("count_after_4", {61'b0, q_count0}, 64'd4);
        chk("no_drop_on_4th", {63'b0, drop0}, 64'd0);
      end
    end
    in_req = 1'b0;
    chk("drop_on_5th", {63'b0, drop0}, 64'd1);
    chk("count_after_drop", {61'b0, q_count0}, 64'd4);
    tick(1);
    chk("drop_one_cycle", {63'b0, drop0}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("no_bubble", {63'b0, ov0}, 64'd1);
    end
    @(negedge clk);
    chk("idle_after_drain", {63'b0, ov0}, 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a word
    sb_beat(0, 2'd1, 64'h5500, 1'b0); sb_beat(0, 2'd1, 64'h6600, 1'b0);
    sb_beat(1, 2'd1, 64'h8800, 1'b0); sb_beat(1, 2'd1, 64'h7700, 1'b0);
    in_req = 1'b1; in_chan = 2'd1; in_data = 32'h55667788;
    tick(1);
    in_chan = 2'd3; in_data = 32'h99AABBCC;
    tick(1);
    in_req = 1'b0;
    tick(2);
    chk("pre_reset_count", {61'b0, q_count0}, 64'd2);
    out_ready = 1'b0; rst_n = 1'b0; in_req = 1'b1;
    tick(1);
    in_req = 1'b0; rst_n = 1'b1;
    chk("post_reset_valid", {63'b0, ov0}, 64'd0);
    chk("post_reset_count", {61'b0, q_count0}, 64'd0);
    chk("post_reset_sb_empty", 64'(q0.size() + q1.size()), 64'd0);
    out_ready = 1'b1;
    sb_in(2'd2, 32'hCAFEF00D);
    in_req = 1'b1; in_chan = 2'd2; in_data = 32'hCAFEF00D;
    tick(1);
    in_req = 1'b0;
    tick(6);

    // Wide configuration, pointer wrap over 7 words
    for (int k = 0; k < 7; k++) begin
      w_req = 1'b1; w_chan = 2'(k % 3);
      w_data = {16'h1000 + 16'(k), 16'h2A00 + 16'(k), 16'h3B00 + 16'(k)};
      sb_word(2, 2'(k % 3), {16'b0, 16'h1000 + 16'(k), 16'h2A00 + 16'(k), 16'h3B00 + 16'(k)});
      tick(1);
      w_req = 1'b0;
      chk("wide_no_drop", {63'b0, wdrop}, 64'd0);
      tick(2);
    end

    budget = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && budget < 100) begin
      tick(1);
      budget++;
    end
    chk("drain_sb0", 64'(q0.size()), 64'd0);
    chk("drain_sb1", 64'(q1.size()), 64'd0);
    chk("drain_sb2", 64'(q2.size()), 64'd0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chan_serializer.md
CHAN_SERIALIZER -- requirements
Module: chan_serializer

Interface
REQ-001 SHALL have parameter DATA_W, 32, input word width.
REQ-002 SHALL have parameter LANE_W, 8, output lane width; BEATS = DATA_W/LANE_W.
REQ-003 SHALL have parameter NUM_CHAN, 4, channel count; CH_W = $clog2(NUM_CHAN).
REQ-004 SHALL have parameter DEPTH, 4, queue entries (any value >= 2, power of 2 not required).
REQ-005 SHALL have parameter MSB_FIRST, 1, beat order: 1 = top lane first, 0 = bottom lane first.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous reset, active low.
REQ-008 SHALL have port in_req  input  1  input word valid.
REQ-009 SHALL have port in_chan  input  CH_W  destination channel.
REQ-010 SHALL have port in_data  input  DATA_W  input word.
REQ-011 SHALL have port q_full  output  1  queue holds DEPTH entries.
REQ-012 SHALL have port q_count  output  $clog2(DEPTH+1)  occupied entries.
REQ-013 SHALL have port drop_err  output  1  one-cycle pulse, in_req rejected.
REQ-014 SHALL have port out_ready  input  1  downstream accepts current beat.
REQ-015 SHALL have port out_valid  output  1  current beat valid.
REQ-016 SHALL have port out_chan  output  CH_W  channel of current beat.
REQ-017 SHALL have port out_data  output  NUM_CHAN*LANE_W  lane c at bits [c*LANE_W +: LANE_W].
REQ-018 SHALL have port out_last  output  1  current beat is final beat of its word.

Function
REQ-019 SHALL push {in_chan,in_data} at an edge where in_req=1 and q_full=0.
REQ-020 SHALL reject the push and pulse drop_err for one cycle when in_req=1 and q_full=1, even if a pop occurs that same edge.
REQ-021 SHALL assert q_full exactly when q_count==DEPTH; all DEPTH entries usable.
REQ-022 SHALL wrap read/write pointers from DEPTH-1 to 0; simultaneous push and pop leave q_count unchanged.
REQ-023 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT when queue non-empty, beat counter loaded with 0.
REQ-024 SHALL assert out_valid in SHIFT only; first beat appears after the edge following the push edge (2-edge latency from in_req).
REQ-025 SHALL present head-entry lane selected by beat counter (MSB_FIRST governs order) on lane out_chan; all other lanes 0.
REQ-026 SHALL hold out_chan, out_data, out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL advance the beat counter only on out_valid&&out_ready.
REQ-028 SHALL assert out_last when beat counter == BEATS-1.
REQ-029 SHALL pop the head on acceptance of the last beat; if queue remains non-empty, stay in SHIFT with beat 0 of next word the following cycle (no bubble); else go to IDLE.
REQ-030 SHALL drive out_chan=0, out_data=0, out_last=0 while out_valid=0.
REQ-031 SHALL fail elaboration if DATA_W%LANE_W!=0, NUM_CHAN<2, or DEPTH<2.

Reset
REQ-032 SHALL, at any edge with rst_n=0, clear pointers, q_count, beat counter, state to IDLE, out_valid, drop_err; queued words discarded, mid-word transfer aborted.
REQ-033 SHALL leave queue storage unreset; outputs follow REQ-030 during reset.
REQ-034 SHALL ignore in_req at any edge with rst_n=0.

Structure
REQ-035 SHALL place state_t (IDLE, SHIFT) and parameter defaults in package chan_ser_pkg.
REQ-036 SHALL implement queue as sub-module chan_ser_fifo (parametrised width/depth, push, pop, count, full, empty).

Verification
REQ-037 Defaults, out_ready=1, push chan=2 data=0xA1B2C3D4 -> 4 beats lane 2 = A1,B2,C3,D4, out_last on D4, out_valid high 4 cycles.
REQ-038 MSB_FIRST=0, same push -> lane 2 = D4,C3,B2,A1.
REQ-039 out_ready low 3 cycles on beat 1 of 0x11223344 chan 0 -> out_data holds 0x22 in lane 0, no beat lost.
REQ-040 Push 5 words back-to-back with out_ready=0 (DEPTH=4) -> q_full after 4th, drop_err pulse on 5th, q_count=4; release ready -> 16 beats, no bubble between words.
REQ-041 rst_n low during beat 2 of a queued word -> next cycle out_valid=0, q_count=0; new push after reset serialises from beat 0.
REQ-042 DATA_W=48, LANE_W=16, NUM_CHAN=3, DEPTH=3 -> 3 beats per word, pointer wrap across 7 words, data intact.
